// File: rtl/mem_lower_pkg.sv
// Shared types and helpers for the 1R1W memory with masked-write RMW.
// FSM state encoding and mask-to-bit expansion.
package mem_lower_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_e;

  localparam int MAX_W = 512;

  // Bit i of the result copies mask bit i/gran; caller truncates to WIDTH.
  function automatic logic [MAX_W-1:0] mask_expand(
    input logic [MAX_W-1:0] mask,
    input int               gran
  );
    logic [MAX_W-1:0] e;
    e = '0;
    for (int i = 0; i < MAX_W; i++) begin
      e[9'(i)] = mask[9'(i / gran)];
    end
    return e;
  endfunction

endpackage

// File: rtl/mem_1r1w_array.sv
// Unmasked word storage: one synchronous read port, one write port.
// Contents are deliberately not reset.
module mem_1r1w_array #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mem_1r1w_rmw.sv
// 1R1W memory with lane-masked writes done as read-modify-write.
// Define MEM_BYPASS_EN to forward same-cycle full-mask write data to reads.
module mem_1r1w_rmw
  import mem_lower_pkg::*;
#(
  parameter  int DEPTH     = 32,
  parameter  int WIDTH     = 64,
  parameter  int MASK_GRAN = 8,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int MASK_W    = WIDTH / MASK_GRAN
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic              R0_ready,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_valid,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  output logic              W0_ready,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [MASK_W-1:0] W0_mask
);

  state_e            state;
  logic [ADDR_W-1:0] rmw_addr;
  logic [WIDTH-1:0]  rmw_data;
  logic [MASK_W-1:0] rmw_mask;

  logic w_full, w_part, w_acc, r_acc;
  logic w_inr, r_inr, rmw_inr, byp_hit;
  logic [WIDTH-1:0]  wmask, merged, arr_q;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_waddr, arr_raddr;
  logic [WIDTH-1:0]  arr_wdata;

  logic             rd_valid, rd_oob, rd_byp;
  logic [WIDTH-1:0] byp_data, hold_q;

  assign w_full   = (W0_mask == '1);
  assign w_part   = (W0_mask != '0) && !w_full;
  assign W0_ready = (state == IDLE);
  assign R0_ready = W0_ready && !(W0_en && w_part);
  assign w_acc    = W0_en && W0_ready;
  assign r_acc    = R0_en && R0_ready;

  assign w_inr   = 32'(W0_addr) < 32'(DEPTH);
  assign r_inr   = 32'(R0_addr) < 32'(DEPTH);
  assign rmw_inr = 32'(rmw_addr) < 32'(DEPTH);

  assign wmask  = WIDTH'(mask_expand(MAX_W'(rmw_mask), MASK_GRAN));
  assign merged = (arr_q & ~wmask) | (rmw_data & wmask);

  // The partial-write fetch borrows the read port; R0_ready is low then.
  assign arr_re    = (r_acc && r_inr) || (w_acc && w_part);
  assign arr_raddr = (w_acc && w_part) ? W0_addr : R0_addr;
  assign arr_we    = (w_acc && w_full && w_inr)
                  || (state == RMW && rmw_inr);
  assign arr_waddr = (state == RMW) ? rmw_addr : W0_addr;
  assign arr_wdata = (state == RMW) ? merged : W0_data;

`ifdef MEM_BYPASS_EN
  assign byp_hit = w_acc && w_full && w_inr
                && (W0_addr == R0_addr);
`else
  assign byp_hit = 1'b0;
`endif

  mem_1r1w_array #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clock  (clock),
    .rd_en  (arr_re),
    .rd_addr(arr_raddr),
    .rd_data(arr_q),
    .wr_en  (arr_we),
    .wr_addr(arr_waddr),
    .wr_data(arr_wdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rmw_addr <= '0;
      rmw_data <= '0;
      rmw_mask <= '0;
    end else if (state == RMW) begin
      state <= IDLE;
    end else if (w_acc && w_part) begin
      state    <= RMW;
      rmw_addr <= W0_addr;
      rmw_data <= W0_data;
      rmw_mask <= W0_mask;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_oob   <= 1'b0;
      rd_byp   <= 1'b0;
      byp_data <= '0;
      hold_q   <= '0;
    end else begin
      rd_valid <= r_acc;
      rd_oob   <= r_acc && !r_inr;
      rd_byp   <= r_acc && byp_hit;
      byp_data <= W0_data;
      hold_q   <= R0_data;
    end
  end

  always_comb begin
    R0_data = hold_q;
    unique case (1'b1)
      !rd_valid: R0_data = hold_q;
      rd_oob:    R0_data = '0;
      rd_byp:    R0_data = byp_data;
      default:   R0_data = arr_q;
    endcase
  end

  assign R0_valid = rd_valid;

endmodule
